// File: rtl/mem_stage.sv
// MIPS memory-access stage: pipeline register, load FSM, load extraction, WB/forward buses.
// Optional MEM_WAIT_EN adds a data_ok handshake and a WAIT state for variable-latency SRAM.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [78:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
`ifdef MEM_WAIT_EN
    input  logic        data_sram_data_ok,
`endif
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_rf_bus,
    output logic        stallreq_for_mem
);

`ifdef MEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, FRESH, HELD, WAIT} state_t;
    localparam state_t LOAD_ST = WAIT;
`else
    typedef enum logic [1:0] {IDLE, FRESH, HELD} state_t;
    localparam state_t LOAD_ST = FRESH;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc, res, hold, hold_nxt, raw, ld, mem_result;
    logic [2:0]  op;
    logic        sel, we, stallreq;
    logic [4:0]  waddr;
    logic [7:0]  lane;
    logic [15:0] half;

    logic bubble, accept, in_load;
    logic unused_stall;

    assign bubble  = stall[3] & ~stall[4];
    assign accept  = ~stall[3];
    assign in_load = ex_to_mem_bus[43] & (ex_to_mem_bus[42:39] == 4'b0000);
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Only the fields consumed downstream are kept; en/wen matter only at entry.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc    <= '0;
            op    <= '0;
            sel   <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            res   <= '0;
        end else if (accept) begin
            pc    <= ex_to_mem_bus[78:47];
            op    <= ex_to_mem_bus[46:44];
            sel   <= ex_to_mem_bus[38];
            we    <= ex_to_mem_bus[37];
            waddr <= ex_to_mem_bus[36:32];
            res   <= ex_to_mem_bus[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        raw       = hold;
        stallreq  = 1'b0;
        unique case (state)
            FRESH: begin
                raw       = data_sram_rdata;
                hold_nxt  = data_sram_rdata;
                state_nxt = HELD;
            end
`ifdef MEM_WAIT_EN
            WAIT: begin
                raw = data_sram_rdata;
                if (data_sram_data_ok) begin
                    hold_nxt  = data_sram_rdata;
                    state_nxt = HELD;
                end else begin
                    stallreq = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        // A new entry (or bubble) overrides whatever the FSM was doing.
        if (bubble)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = in_load ? LOAD_ST : IDLE;
    end

    always_comb begin
        unique case (res[1:0])
            2'd0:    lane = raw[7:0];
            2'd1:    lane = raw[15:8];
            2'd2:    lane = raw[23:16];
            default: lane = raw[31:24];
        endcase
        half = res[1] ? raw[31:16] : raw[15:0];
        unique case (op)
            3'b001:  ld = {{24{lane[7]}}, lane};
            3'b010:  ld = {24'b0, lane};
            3'b011:  ld = {{16{half[15]}}, half};
            3'b100:  ld = {16'b0, half};
            default: ld = raw;
        endcase
    end

    assign mem_result       = sel ? ld : res;
    assign mem_to_rf_bus    = {we, waddr, mem_result};
    assign mem_to_wb_bus    = {pc, we, waddr, mem_result};
    assign stallreq_for_mem = stallreq;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver queues hand-computed expectations, monitor checks at negedge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [78:0] ex_bus = '0;
    logic [31:0] rdata = '0;
    logic        dok = 1'b1;
    logic [69:0] wb_bus;
    logic [37:0] rf_bus;
    logic        stallreq;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_bus),
        .data_sram_rdata  (rdata),
`ifdef MEM_WAIT_EN
        .data_sram_data_ok(dok),
`endif
        .mem_to_wb_bus    (wb_bus),
        .mem_to_rf_bus    (rf_bus),
        .stallreq_for_mem (stallreq)
    );

    typedef struct packed {
        logic        chk;
        logic [69:0] wb;
        logic        sr;
    } exp_t;

    exp_t sbq[$];
    int   applied = 0;
    int   miscompares = 0;

    localparam logic [5:0] GO   = 6'b000000;
    localparam logic [5:0] HOLD = 6'b011000;
    localparam logic [5:0] BUB  = 6'b001000;

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] r);
        return {pc, op, en, wen, sel, we, wa, r};
    endfunction

    function automatic logic [69:0] ew(input logic [31:0] pc, input logic we,
                                       input logic [4:0] wa, input logic [31:0] r);
        return {pc, we, wa, r};
    endfunction

    task automatic apply(input logic r, input logic [5:0] st, input logic [78:0] bus,
                         input logic [31:0] rd, input logic ok, input logic chk,
                         input logic [69:0] ewb, input logic esr);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = r;
        stall  = st;
        ex_bus = bus;
        rdata  = rd;
        dok    = ok;
        e.chk  = chk;
        e.wb   = ewb;
        e.sr   = esr;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
                applied++;
                if (wb_bus !== e.wb) begin
                    miscompares++;
                    $display("FAIL wb_bus got %h want %h", wb_bus, e.wb);
                end
                applied++;
                if (rf_bus !== e.wb[37:0]) begin
                    miscompares++;
                    $display("FAIL rf_bus got %h want %h", rf_bus, e.wb[37:0]);
                end
            end
            applied++;
            if (stallreq !== e.sr) begin
                miscompares++;
                $display("FAIL stallreq got %b want %b", stallreq, e.sr);
            end
        end
    end

    initial begin
        logic [78:0] alu_a, lb, lbu, lh, lhu, lw, st_w, alu_b, alu_c, lw5, ld_d, ld_d2;
        alu_a = mk(32'h100, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5,  32'h1234);
        lb    = mk(32'h104, 3'd1, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h1002);
        lbu   = mk(32'h108, 3'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h1002);
        lh    = mk(32'h10C, 3'd3, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h2002);
        lhu   = mk(32'h110, 3'd4, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h2003);
        lw    = mk(32'h114, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h3001);
        st_w  = mk(32'h118, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h4000);
        alu_b = mk(32'h11C, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h5555AAAA);
        alu_c = mk(32'h120, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd13, 32'h77);
        lw5   = mk(32'h124, 3'd5, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h6003);
        ld_d  = mk(32'h200, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd15, 32'h8000);
        ld_d2 = mk(32'h204, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd16, 32'h8004);

        apply(1, GO,   '0,    '0,           1, 1, '0, 0);
        apply(0, GO,   alu_a, '0,           1, 1, '0, 0);
        apply(0, GO,   lb,    '0,           1, 1, ew(32'h100, 1, 5'd5, 32'h00001234), 0);
        apply(0, GO,   lbu,   32'h1280FF00, 1, 1, ew(32'h104, 1, 5'd6, 32'hFFFFFF80), 0);
        apply(0, GO,   lh,    32'h1280FF00, 1, 1, ew(32'h108, 1, 5'd7, 32'h00000080), 0);
        apply(0, GO,   lhu,   32'h80017FFF, 1, 1, ew(32'h10C, 1, 5'd8, 32'hFFFF8001), 0);
        apply(0, GO,   lw,    32'h80017FFF, 1, 1, ew(32'h110, 1, 5'd9, 32'h00008001), 0);
        apply(0, HOLD, st_w,  32'hDEADBEEF, 1, 1, ew(32'h114, 1, 5'd10, 32'hDEADBEEF), 0);
        apply(0, HOLD, st_w,  32'h00000000, 1, 1, ew(32'h114, 1, 5'd10, 32'hDEADBEEF), 0);
        apply(0, HOLD, st_w,  32'h11111111, 1, 1, ew(32'h114, 1, 5'd10, 32'hDEADBEEF), 0);
        apply(0, GO,   st_w,  32'h00000000, 1, 1, ew(32'h114, 1, 5'd10, 32'hDEADBEEF), 0);
        apply(0, GO,   alu_b, '0,           1, 1, ew(32'h118, 0, 5'd0, 32'h00004000), 0);
        apply(0, BUB,  alu_c, '0,           1, 1, ew(32'h11C, 1, 5'd12, 32'h5555AAAA), 0);
        apply(0, GO,   alu_c, '0,           1, 1, '0, 0);
        apply(0, GO,   '0,    '0,           1, 1, ew(32'h120, 1, 5'd13, 32'h00000077), 0);
        apply(0, GO,   lw5,   '0,           1, 1, '0, 0);
        apply(0, GO,   '0,    32'hA5A55A5A, 1, 1, ew(32'h124, 1, 5'd14, 32'hA5A55A5A), 0);
        apply(0, GO,   '0,    '0,           1, 1, '0, 0);
        apply(1, GO,   alu_a, '0,           1, 1, '0, 0);
        apply(0, GO,   '0,    '0,           1, 1, '0, 0);
`ifdef MEM_WAIT_EN
        apply(0, GO,   ld_d,  '0,           0, 1, '0, 0);
        apply(0, HOLD, '0,    '0,           0, 0, '0, 1);
        apply(0, HOLD, '0,    '0,           0, 0, '0, 1);
        apply(0, HOLD, '0,    32'hCAFEF00D, 1, 1, ew(32'h200, 1, 5'd15, 32'hCAFEF00D), 0);
        apply(0, GO,   ld_d2, '0,           0, 1, ew(32'h200, 1, 5'd15, 32'hCAFEF00D), 0);
        apply(1, HOLD, '0,    '0,           0, 0, '0, 1);
        apply(0, GO,   '0,    32'h12345678, 1, 1, '0, 0);
        apply(0, GO,   '0,    '0,           0, 1, '0, 0);
`else
        apply(0, GO,   ld_d,  '0,           1, 1, '0, 0);
        apply(0, GO,   ld_d2, 32'hCAFEF00D, 1, 1, ew(32'h200, 1, 5'd15, 32'hCAFEF00D), 0);
        apply(1, GO,   '0,    '0,           1, 0, '0, 0);
        apply(0, GO,   '0,    32'h12345678, 1, 1, '0, 0);
`endif
        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It registers the execute-to-memory bus under the global stall vector and keeps load data stable across stalls. It extracts and extends byte, halfword and word load data, then produces the write-back bus and the register-file forwarding bus for the decode stage.

## Interface
- No parameters; widths fixed: input bus 79 bits, WB bus 70 bits, forward bus 38 bits.
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  global stall vector, 1 = Stop; bit 3 = this stage, bit 4 = write-back.
- ex_to_mem_bus  in  79  {ex_pc[78:47], mem_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rdata  in  32  data SRAM read data for the access issued by EX.
- data_sram_data_ok  in  1  read-data valid strobe; present only with MEM_WAIT_EN.
- mem_to_wb_bus  out  70  {mem_pc[69:38], rf_we[37], rf_waddr[36:32], mem_result[31:0]}.
- mem_to_rf_bus  out  38  {rf_we[37], rf_waddr[36:32], mem_result[31:0]}; forwarding to ID.
- stallreq_for_mem  out  1  stall request to the stall controller.

## Operation
- Pipeline register R, updated in this priority order:
  - rst: R = 0.
  - stall[3]=1 and stall[4]=0: R = 0 (bubble).
  - stall[3]=0: R = ex_to_mem_bus.
  - otherwise R holds.
- A load is an entry with data_ram_en=1 and data_ram_wen=0. Stores and ALU ops bypass the load FSM.
- Load FSM states:
  - IDLE: no load in R.
  - FRESH: first cycle of a load in R. raw = data_sram_rdata; the hold register captures it. Next state is HELD.
  - HELD: raw = hold register.
  - A new entry loaded into R always re-enters FRESH (load) or IDLE (non-load), regardless of the current state.
- FRESH→HELD occurs even while stall[3]=1. The held data must survive any number of stall cycles.
- Load extraction:
  - off = ex_result[1:0]. Lanes are little-endian: off 0 → raw[7:0]; halfword select is ex_result[1] (0 → raw[15:0]).
  - mem_op 001 LB: sign-extend byte. 010 LBU: zero-extend byte.
  - mem_op 011 LH: sign-extend half. 100 LHU: zero-extend half.
  - mem_op 000 and 101–111: LW, raw unchanged.
  - LH/LHU ignore ex_result[0]; LW ignores ex_result[1:0]. No misalignment detection.
- mem_result = sel_rf_res ? extracted load : ex_result.
- Both output buses are driven combinationally from R and mem_result.
- Without MEM_WAIT_EN, stallreq_for_mem is constant 0.

## Timing
- Reset values: R=0, state IDLE, hold=0. Hence mem_to_wb_bus=0, mem_to_rf_bus=0, stallreq_for_mem=0.
- Latency: an entry accepted at edge N drives outputs during cycle N+1. Without MEM_WAIT_EN the load result is valid in that same cycle, from live rdata.
- Forward bus and WB bus carry identical rf_we/rf_waddr/mem_result in every cycle.
- A bubble cycle outputs rf_we=0, so no spurious write-back or forward occurs.
- rst asserted in any state (including WAIT) forces reset values at the next edge. A pending data_ok that arrives afterwards is ignored.

## Configuration
- MEM_WAIT_EN defined:
  - Adds the data_sram_data_ok port and a WAIT state, which replaces FRESH for loads.
  - In WAIT: stallreq_for_mem = !data_sram_data_ok.
  - In the data_ok cycle: raw = live rdata, hold captures it, stallreq=0, next state HELD.
  - data_ok while IDLE or HELD is ignored.
  - data_ok arriving while stall[3]=1 from another source is still captured.
- MEM_WAIT_EN undefined: no port and no WAIT state. The SRAM is fixed one-cycle latency and the FRESH/HELD behaviour above applies.

## Test plan
- Reset, then apply a non-load entry with rf_we=1, waddr=5, ex_result=0x1234 → next cycle both buses show rf_we=1, waddr=5, result 0x00001234; stallreq=0.
- LB with ex_result[1:0]=2, rdata=0x1280_FF00 → result 0xFFFFFF80. Repeat as LBU → 0x00000080.
- LH with ex_result=0x...2, rdata=0x8001_7FFF → result 0xFFFF8001. Repeat as LHU → 0x00008001.
- LW with rdata=0xDEADBEEF, then stall[3]=1 for 3 cycles while rdata changes to 0x0 → result stays 0xDEADBEEF for all 4 cycles.
- stall[3]=1, stall[4]=0 → next cycle both buses are all zero, and the previous entry is not repeated.
- With MEM_WAIT_EN: load with data_ok low for 2 cycles → stallreq=1 for exactly 2 cycles. In the third cycle data_ok=1, rdata=0xCAFEF00D → stallreq=0 and result 0xCAFEF00D. Asserting rst during WAIT → outputs zero next cycle.
